// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, block alignment mask, bridge state type and beat address helper
package cache_pkg;
  localparam int WORD_SIZE = 32;
  localparam int BLOCK_DATA_WIDTH = 512;
  localparam int BEATS = BLOCK_DATA_WIDTH / WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] BLOCK_ALIGN_MASK = ~32'h3F;
  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_ADDR, RD_WAIT, DONE} bridge_state_t;
  function automatic logic [WORD_SIZE-1:0] beat_addr(input logic [WORD_SIZE-1:0] base, input logic [3:0] beat);
    return base + {{(WORD_SIZE-6){1'b0}}, beat, 2'b00};
  endfunction
endpackage

// File: rtl/mem_beat_buffer.sv
// mem_beat_buffer: 16x32 line buffer with block load, indexed word write/read and full-block read-out
module mem_beat_buffer
  import cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [BLOCK_DATA_WIDTH-1:0] block_in,
  input  logic                        we,
  input  logic [3:0]                  widx,
  input  logic [WORD_SIZE-1:0]        wdata,
  input  logic [3:0]                  ridx,
  output logic [WORD_SIZE-1:0]        rdata,
  output logic [BLOCK_DATA_WIDTH-1:0] block_out
);
  logic [BEATS-1:0][WORD_SIZE-1:0] mem;
  always_ff @(posedge clk)
    if (rst) mem <= '0;
    else if (load) mem <= block_in;
    else if (we) mem[widx] <= wdata;
  assign rdata = mem[ridx];
  assign block_out = mem;
endmodule

// File: rtl/mem_block_bridge.sv
// mem_block_bridge: splits 512-bit block reads/writes into 16 single-word bus beats with enable/ready handshake
module mem_block_bridge
  import cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_req_enable,
  input  logic                        mem_req_rw,
  input  logic [WORD_SIZE-1:0]        mem_req_addr,
  input  logic [BLOCK_DATA_WIDTH-1:0] mem_req_dataout,
  output logic [BLOCK_DATA_WIDTH-1:0] mem_req_datain,
  output logic                        mem_req_ready,
  output logic                        bus_valid,
  input  logic                        bus_ready,
  output logic                        bus_we,
  output logic [WORD_SIZE-1:0]        bus_addr,
  output logic [WORD_SIZE-1:0]        bus_wdata,
  input  logic                        bus_rvalid,
  input  logic [WORD_SIZE-1:0]        bus_rdata
);
  bridge_state_t state;
  logic [WORD_SIZE-1:0] base;
  logic [WORD_SIZE-1:0] rd_word;
  logic [3:0] beat;
  logic [3:0] nxt;
  logic load;
  logic store;
  assign nxt = beat + 4'd1;
  assign load = state == IDLE && mem_req_enable && mem_req_rw;
  assign store = state == RD_WAIT && bus_rvalid;
  mem_beat_buffer u_buf (
    .clk(clk),
    .rst(rst),
    .load(load),
    .block_in(mem_req_dataout),
    .we(store),
    .widx(beat),
    .wdata(bus_rdata),
    .ridx(nxt),
    .rdata(rd_word),
    .block_out(mem_req_datain)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      base <= '0;
      beat <= '0;
      bus_valid <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wdata <= '0;
      mem_req_ready <= 1'b0;
    end else
      case (state)
        IDLE:
          if (mem_req_enable) begin
            base <= mem_req_addr & BLOCK_ALIGN_MASK;
            beat <= '0;
            bus_valid <= 1'b1;
            bus_we <= mem_req_rw;
            bus_addr <= mem_req_addr & BLOCK_ALIGN_MASK;
            bus_wdata <= mem_req_rw ? mem_req_dataout[WORD_SIZE-1:0] : '0;
            state <= mem_req_rw ? WR_BEAT : RD_ADDR;
          end
        WR_BEAT:
          if (bus_ready) begin
            if (beat == 4'(BEATS-1)) begin
              bus_valid <= 1'b0;
              bus_we <= 1'b0;
              mem_req_ready <= 1'b1;
              state <= DONE;
            end else begin
              beat <= nxt;
              bus_addr <= beat_addr(base, nxt);
              bus_wdata <= rd_word;
            end
          end
        RD_ADDR:
          if (bus_ready) begin
            bus_valid <= 1'b0;
            state <= RD_WAIT;
          end
        RD_WAIT:
          if (bus_rvalid) begin
            if (beat == 4'(BEATS-1)) begin
              mem_req_ready <= 1'b1;
              state <= DONE;
            end else begin
              beat <= nxt;
              bus_valid <= 1'b1;
              bus_addr <= beat_addr(base, nxt);
              state <= RD_ADDR;
            end
          end
        DONE:
          if (!mem_req_enable) begin
            mem_req_ready <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mem_block_bridge.sv
// tb_mem_block_bridge: table-driven block transfers with a bus scoreboard plus reset/spurious-rvalid sequences
module tb_mem_block_bridge;
  logic clk;
  logic rst;
  logic mem_req_enable;
  logic mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [511:0] mem_req_dataout;
  logic [511:0] mem_req_datain;
  logic mem_req_ready;
  logic bus_valid;
  logic bus_ready;
  logic bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic bus_rvalid;
  logic [31:0] bus_rdata;
  logic rvalid_auto;
  logic [31:0] rdata_auto;
  logic rv_force;
  logic [31:0] force_data;
  logic [31:0] rd_seed;
  int total;
  int bad;
  typedef struct packed {
    logic we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;
  beat_t exp_q[$];
  beat_t e;
  typedef struct {
    logic rw;
    logic [31:0] addr;
    logic [31:0] seed;
    int stall_beat;
    int stall_len;
    int exp_cyc;
    int hold;
    logic spur;
  } vec_t;
  vec_t vecs[6];
  mem_block_bridge dut (
    .clk(clk),
    .rst(rst),
    .mem_req_enable(mem_req_enable),
    .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr),
    .mem_req_dataout(mem_req_dataout),
    .mem_req_datain(mem_req_datain),
    .mem_req_ready(mem_req_ready),
    .bus_valid(bus_valid),
    .bus_ready(bus_ready),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign bus_rvalid = rvalid_auto | rv_force;
  assign bus_rdata = rv_force ? force_data : rdata_auto;
  always @(posedge clk) begin
    rvalid_auto <= 1'b0;
    if (!rst && bus_valid && bus_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat got we=%b addr=%h want no beat", bus_we, bus_addr);
      end else begin
        e = exp_q.pop_front();
        if (bus_we !== e.we || bus_addr !== e.addr || (e.we && bus_wdata !== e.data)) begin
          bad++;
          $display("FAIL bus_beat got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                   bus_we, bus_addr, bus_wdata, e.we, e.addr, e.data);
        end
      end
      if (!bus_we) begin
        rvalid_auto <= 1'b1;
        rdata_auto <= rd_seed + ((bus_addr & 32'h3F) >> 2);
      end
    end
  end
  task automatic check(input string name, input logic [543:0] got, input logic [543:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  task automatic run_vec(input vec_t v);
    logic [511:0] blk;
    logic [31:0] base;
    int got;
    base = v.addr & 32'hFFFF_FFC0;
    rd_seed = v.seed;
    for (int i = 0; i < 16; i++) begin
      blk[i*32 +: 32] = v.seed + 32'(i);
      exp_q.push_back(beat_t'{we: v.rw, addr: base + 32'(4 * i), data: v.seed + 32'(i)});
    end
    @(negedge clk);
    mem_req_enable = 1'b1;
    mem_req_rw = v.rw;
    mem_req_addr = v.addr;
    mem_req_dataout = blk;
    got = 0;
    for (int n = 1; n <= v.exp_cyc + 10 && got == 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("first_valid", 544'({bus_valid, bus_we, bus_addr}), 544'({1'b1, v.rw, base}));
        mem_req_addr = ~v.addr;
        mem_req_dataout = ~blk;
        mem_req_rw = ~v.rw;
      end
      bus_ready = !(v.stall_len > 0 && n >= v.stall_beat + 1 && n < v.stall_beat + 1 + v.stall_len);
      if (v.stall_len > 0 && n >= v.stall_beat + 1 && n <= v.stall_beat + 1 + v.stall_len)
        check("stall_hold", 544'({bus_valid, bus_addr, bus_wdata}),
              544'({1'b1, base + 32'(4 * v.stall_beat), v.seed + 32'(v.stall_beat)}));
      rv_force = v.spur && (n % 3 == 0);
      force_data = 32'h5555_AAAA;
      if (mem_req_ready) got = n;
    end
    rv_force = 1'b0;
    bus_ready = 1'b1;
    check("done_cycle", 544'(got), 544'(v.exp_cyc));
    check("block_data", 544'(mem_req_datain), 544'(blk));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check("held_enable", 544'({mem_req_ready, bus_valid}), 544'(2'b10));
    end
    mem_req_enable = 1'b0;
    @(negedge clk);
    check("ready_fall", 544'(mem_req_ready), 544'(0));
    check("beats_drained", 544'(exp_q.size()), 544'(0));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [511:0] blk;
    total = 0;
    bad = 0;
    rst = 1'b1;
    mem_req_enable = 1'b0;
    mem_req_rw = 1'b0;
    mem_req_addr = '0;
    mem_req_dataout = '0;
    bus_ready = 1'b1;
    rv_force = 1'b0;
    force_data = '0;
    rd_seed = '0;
    vecs[0] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 0, 0, 17, 0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0ABC, 32'hCAFE_0000, 0, 0, 33, 0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 5, 3, 20, 0, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 32'h1111_0000, 0, 0, 17, 4, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_0040, 32'hABCD_0000, 0, 0, 33, 0, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_07C4, 32'h0F0F_0000, 0, 0, 17, 0, 1'b1};
    repeat (3) @(negedge clk);
    check("reset_outputs", 544'({bus_valid, bus_we, bus_addr, bus_wdata, mem_req_ready, mem_req_datain}), 544'(0));
    rst = 1'b0;
    for (int k = 0; k < 5; k++) run_vec(vecs[k]);
    for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'hABCD_0000 + 32'(i);
    force_data = 32'h1234_5678;
    rv_force = 1'b1;
    repeat (2) @(negedge clk);
    rv_force = 1'b0;
    @(negedge clk);
    check("idle_spurious", 544'({bus_valid, mem_req_datain}), 544'({1'b0, blk}));
    run_vec(vecs[5]);
    rd_seed = 32'h7777_0000;
    for (int i = 0; i < 16; i++) exp_q.push_back(beat_t'{we: 1'b0, addr: 32'h2000 + 32'(4 * i), data: 32'h0});
    @(negedge clk);
    mem_req_enable = 1'b1;
    mem_req_rw = 1'b0;
    mem_req_addr = 32'h0000_2010;
    for (int n = 1; n <= 16; n++) @(negedge clk);
    check("rd_wait_beat7", 544'({bus_valid, mem_req_ready}), 544'(0));
    rst = 1'b1;
    mem_req_enable = 1'b0;
    @(negedge clk);
    check("reset_abort", 544'({bus_valid, bus_we, bus_addr, bus_wdata, mem_req_ready, mem_req_datain}), 544'(0));
    check("beats_left", 544'(exp_q.size()), 544'(8));
    exp_q.delete();
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("post_reset_idle", 544'({bus_valid, mem_req_ready}), 544'(0));
    end
    run_vec(vecs[0]);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_block_bridge.md
# mem_block_bridge

Memory-side bridge between the cache controller's block-wide memory port and a 32-bit word-wide main-memory bus. It accepts one 512-bit block read (refill) or write (write-back/eviction) at a time from the controller. Each request becomes a burst of 16 single-word bus transactions; the bridge then returns read data or completion over a four-phase enable/ready handshake. It sits directly downstream of the cache controller's `mem_req_*` port.

## Interface
- `WORD_SIZE`, 32: bus word width and address width.
- `BLOCK_DATA_WIDTH`, 512: cache block width.
- `BEATS`, `BLOCK_DATA_WIDTH/WORD_SIZE` = 16: words per block.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req_enable`  in  1  request from the cache controller, held until `mem_req_ready`.
- `mem_req_rw`  in  1  request type: 1 = write block to memory, 0 = read block.
- `mem_req_addr`  in  WORD_SIZE  byte address; the low 6 bits are ignored.
- `mem_req_dataout`  in  BLOCK_DATA_WIDTH  write block from the controller.
- `mem_req_datain`  out  BLOCK_DATA_WIDTH  read block to the controller.
- `mem_req_ready`  out  1  completion, held until `mem_req_enable` is low.
- `bus_valid`  out  1  word transaction request.
- `bus_ready`  in  1  memory accepts the transaction.
- `bus_we`  out  1  1 = word write.
- `bus_addr`  out  WORD_SIZE  word byte address.
- `bus_wdata`  out  WORD_SIZE  write word.
- `bus_rvalid`  in  1  read word returned.
- `bus_rdata`  in  WORD_SIZE  read word.

## Operation
- FSM states: IDLE, WR_BEAT, RD_ADDR, RD_WAIT, DONE.
- **IDLE.** When `mem_req_enable`=1:
  - latch `rw`;
  - latch base = `addr & ~0x3F`;
  - if rw=1, latch `mem_req_dataout` into the line buffer;
  - clear the beat counter `beat`;
  - go to WR_BEAT if rw=1, else RD_ADDR.
- **WR_BEAT.** Drive:
  - `bus_valid`=1, `bus_we`=1;
  - `bus_addr` = base + 4·beat;
  - `bus_wdata` = buffer[beat·32 +: 32].
  - On `bus_valid & bus_ready`: if beat==15 go to DONE, else increment beat.
- **RD_ADDR.** Drive `bus_valid`=1, `bus_we`=0, `bus_addr` = base + 4·beat. On `bus_ready`, go to RD_WAIT.
- **RD_WAIT.** `bus_valid`=0. On `bus_rvalid`:
  - store `bus_rdata` into buffer[beat·32 +: 32];
  - if beat==15 go to DONE, else increment beat and go to RD_ADDR.
- **DONE.** Drive `mem_req_ready`=1. When `mem_req_enable` is sampled low, go to IDLE.
- Only one bus read is outstanding at a time. `bus_rvalid` outside RD_WAIT is ignored.
- Beat 0 maps to block bits [31:0]. The beat counter is 4 bits and never wraps mid-burst: 15 is terminal.
- Beat address arithmetic is WORD_SIZE bits wide. No carry out of the block is possible because the base is 64-byte aligned.
- `mem_req_datain` is driven from the line buffer at all times. It is valid while `mem_req_ready`=1 after a read.
- The line buffer is not cleared on write completion.
- Changes to `mem_req_addr`, `mem_req_rw` or `mem_req_dataout` after the request is latched are ignored.

## Timing
- Reset values: `bus_valid`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `mem_req_ready`=0, `mem_req_datain`=0. The state returns to IDLE.
- `rst` mid-burst aborts immediately:
  - `bus_valid` is low in the next cycle;
  - no further beats are issued;
  - a returning `bus_rvalid` is dropped.
- `bus_valid` and all bus payload signals are held stable until `bus_ready` is sampled high.
- `mem_req_enable` sampled in cycle 0 puts the first `bus_valid` in cycle 1.
- Write burst with `bus_ready` tied high:
  - beats occupy cycles 1–16;
  - `mem_req_ready` is high from cycle 17.
- Read burst with `bus_ready`=1 and `bus_rvalid` one cycle after acceptance:
  - 2 cycles per beat;
  - `mem_req_ready` is high from cycle 33.
- `mem_req_ready` falls the cycle after `mem_req_enable` is sampled low.
- A new request is accepted no earlier than the following cycle.
- An enable held high in DONE never causes a second burst.

## Structure
- Shared package `cache_pkg`:
  - `WORD_SIZE`, `BLOCK_DATA_WIDTH`, `BEATS`;
  - `BLOCK_ALIGN_MASK` (`~32'h3F`);
  - state enum type `bridge_state_t`.
- One sub-module, `mem_beat_buffer`:
  - 16×32 line buffer;
  - parallel block load and word write by index;
  - word read by index;
  - full-block read-out.
- The FSM and beat counter stay in `mem_block_bridge`.

## Test plan
- **Write block.**
  - Stimulus: write to 0x0000_1234 with word i = 0xDEADBEEF+i, `bus_ready`=1.
  - Required: 16 writes to 0x1200, 0x1204 … 0x123C with data 0xDEADBEEF … 0xDEADBEFE; `mem_req_ready` rises in cycle 17.
- **Read block.**
  - Stimulus: read at 0x0000_0ABC; memory returns 0xCAFE0000+i one cycle after each acceptance.
  - Required: addresses 0xA80 … 0xABC; `mem_req_datain` word i = 0xCAFE0000+i when `mem_req_ready`=1 at cycle 33.
- **Backpressure.**
  - Stimulus: `bus_ready`=0 for 3 cycles at write beat 5.
  - Required: `bus_addr`=base+0x14 and `bus_wdata` held constant for the whole stall; completion is 3 cycles later (cycle 20).
- **Held enable.**
  - Stimulus: `mem_req_enable` kept high 4 cycles after `mem_req_ready`.
  - Required: `mem_req_ready` stays high, no `bus_valid`; ready falls the cycle after enable drops.
- **Reset mid-read.**
  - Stimulus: `rst` at beat 7 while in RD_WAIT; `bus_rvalid` arrives during reset.
  - Required: all outputs at reset values next cycle; the word is not stored.
  - Follow-up: a subsequent write is serviced normally from beat 0.
- **Spurious rvalid.**
  - Stimulus: `bus_rvalid` pulsed in IDLE and WR_BEAT.
  - Required: buffer unchanged; the write data stream is unaffected.
